// File: rtl/johnson_ctrl_pkg.sv
// Shared types and Johnson-code decode helpers for the Johnson step controller.
// The decode functions take a zero-extended vector plus the live stage count.
package johnson_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_RUN    = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RUN_TO = 2'd3
    } op_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned JC_MAX_W = 64;

    // Legal Johnson code: at most one transition between adjacent stages, no wrap.
    function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] v, input int unsigned w);
        logic [JC_MAX_W-1:0] s;
        int unsigned         n;
        n = 0;
        for (int unsigned i = 0; i < JC_MAX_W - 1; i++) begin
            s = v >> i;
            if ((i + 1 < w) && (s[0] != s[1])) begin
                n++;
            end
        end
        return (n <= 1);
    endfunction

    function automatic int unsigned jc_phase(input logic [JC_MAX_W-1:0] v, input int unsigned w);
        logic [JC_MAX_W-1:0] s;
        int unsigned         pop;
        logic                msb;
        pop = 0;
        for (int unsigned i = 0; i < JC_MAX_W; i++) begin
            s = v >> i;
            if ((i < w) && s[0]) begin
                pop++;
            end
        end
        s   = v >> (w - 1);
        msb = s[0];
        if (!jc_is_legal(v, w)) begin
            return 0;
        end
        return msb ? (2 * w - pop) : pop;
    endfunction

endpackage

// File: rtl/johnson_shift_reg.sv
// Enable-gated Johnson shift register with clear and parallel load.
// Priority: reset > clr > ld > en; holds otherwise.
module johnson_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (en) begin
            r_q <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven sequencer stepping a Johnson shift register a counted number of times,
// with phase/legal decode, sticky error and a one-cycle completion pulse.
module johnson_step_ctrl
    import johnson_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned PH_W = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             abort,
    input  logic             err_clr,
    output logic [WIDTH-1:0] jc_q,
    output logic             legal,
    output logic [PH_W-1:0]  phase,
    output logic [CNT_W-1:0] steps_left,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] TWO_W = CNT_W'(2 * WIDTH);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_steps;
    logic             r_done;
    logic             r_err;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_steps_nxt;
    logic             w_done_nxt;
    logic             w_err_set;
    logic             w_shift;
    logic             w_ld;
    logic             w_clr;
    logic             w_accept;
    logic [CNT_W-1:0] w_phase_ext;
    logic [CNT_W-1:0] w_to_steps;

    johnson_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_shift),
        .ld    (w_ld),
        .clr   (w_clr),
        .d     (cmd_arg[WIDTH-1:0]),
        .q     (jc_q)
    );

    assign legal       = jc_is_legal(JC_MAX_W'(jc_q), WIDTH);
    assign phase       = PH_W'(jc_phase(JC_MAX_W'(jc_q), WIDTH));
    assign w_phase_ext = CNT_W'(phase);
    assign cmd_ready   = !reset && (r_state == ST_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;

    // Distance forward to the target phase, modulo 2*WIDTH; only used when target < 2*WIDTH.
    assign w_to_steps = (cmd_arg >= w_phase_ext) ? (cmd_arg - w_phase_ext)
                                                 : (cmd_arg + TWO_W - w_phase_ext);

    always_comb begin
        w_state_nxt = r_state;
        w_steps_nxt = r_steps;
        w_done_nxt  = 1'b0;
        w_err_set   = 1'b0;
        w_shift     = 1'b0;
        w_ld        = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (op_e'(cmd_op))
                        OP_LOAD: begin
                            w_ld       = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                        OP_CLEAR: begin
                            w_clr      = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                        OP_RUN: begin
                            if (!legal) begin
                                w_err_set  = 1'b1;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_steps_nxt = cmd_arg;
                                if (cmd_arg == '0) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_RUN;
                                end
                            end
                        end
                        OP_RUN_TO: begin
                            if (!legal || (cmd_arg >= TWO_W)) begin
                                w_err_set  = 1'b1;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_steps_nxt = w_to_steps;
                                if (w_to_steps == '0) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_RUN;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_shift     = 1'b1;
                    w_steps_nxt = r_steps - CNT_W'(1);
                    if (r_steps == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_steps <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_steps <= w_steps_nxt;
            r_done  <= w_done_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign steps_left = r_steps;
    assign busy       = (r_state == ST_RUN);
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Directed bench for johnson_step_ctrl (WIDTH=8, CNT_W=8) with hand-computed expectations.
module tb_johnson_step_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       abort;
    logic       err_clr;
    logic [7:0] jc_q;
    logic       legal;
    logic [3:0] phase;
    logic [7:0] steps_left;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    johnson_step_ctrl #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .abort      (abort),
        .err_clr    (err_clr),
        .jc_q       (jc_q),
        .legal      (legal),
        .phase      (phase),
        .steps_left (steps_left),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command and return #1 after its accept edge.
    task automatic send(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 8'd0;
        abort     = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        check("rst_ready", cmd_ready, 0);
        check("rst_jc", jc_q, 8'h00);
        check("rst_steps", steps_left, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        check("rel_ready", cmd_ready, 1);
        check("rst_phase", phase, 0);

        // RUN 5 from 0x00: busy for 5 cycles, then 0x1F phase 5 with done
        send(2'd1, 8'd5);
        check("run5_steps0", steps_left, 5);
        for (int i = 0; i < 5; i++) begin
            check("run5_busy", busy, 1);
            check("run5_nodone", done, 0);
            check("run5_noready", cmd_ready, 0);
            tick();
        end
        check("run5_jc", jc_q, 8'h1F);
        check("run5_phase", phase, 5);
        check("run5_done", done, 1);
        check("run5_idle", busy, 0);
        check("run5_ready", cmd_ready, 1);

        // LOAD accepted back-to-back with the done pulse
        send(2'd0, 8'h0F);
        check("load_jc", jc_q, 8'h0F);
        check("load_phase", phase, 4);
        check("load_done", done, 1);
        send(2'd3, 8'd12);
        check("rto_steps", steps_left, 8);
        check("rto_busy", busy, 1);
        check("rto_nodone_e0", done, 0);
        repeat (7) tick();
        check("rto_nodone_e7", done, 0);
        tick();
        check("rto_jc", jc_q, 8'hF0);
        check("rto_phase", phase, 12);
        check("rto_done", done, 1);
        tick();
        check("rto_done_once", done, 0);

        // Illegal pattern and error handling
        send(2'd0, 8'h05);
        check("ill_legal", legal, 0);
        check("ill_phase", phase, 0);
        send(2'd1, 8'd3);
        check("rej_err", err, 1);
        check("rej_jc", jc_q, 8'h05);
        check("rej_done", done, 1);
        check("rej_busy", busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("errclr", err, 0);
        check("errclr_done", done, 0);
        err_clr = 1'b1;
        send(2'd1, 8'd3);
        err_clr = 1'b0;
        check("set_beats_clr", err, 1);
        tick();
        check("err_sticky", err, 1);
        send(2'd2, 8'h00);
        check("clear_jc", jc_q, 8'h00);
        check("clear_keeps_err", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        send(2'd3, 8'd16);
        check("rto_range_err", err, 1);
        check("rto_range_jc", jc_q, 8'h00);
        check("rto_range_busy", busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Wrap-around and zero-step commands
        send(2'd1, 8'd16);
        repeat (16) tick();
        check("run16_jc", jc_q, 8'h00);
        check("run16_done", done, 1);
        send(2'd1, 8'd20);
        repeat (20) tick();
        check("run20_jc", jc_q, 8'h0F);
        check("run20_phase", phase, 4);
        check("run20_done", done, 1);
        send(2'd1, 8'd0);
        check("run0_done", done, 1);
        check("run0_jc", jc_q, 8'h0F);
        check("run0_busy", busy, 0);
        send(2'd3, 8'd4);
        check("rto_here_done", done, 1);
        check("rto_here_jc", jc_q, 8'h0F);
        check("rto_here_busy", busy, 0);
        check("no_err", err, 0);

        // Abort after edge 2 of RUN 10
        send(2'd2, 8'h00);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_ignored", jc_q, 8'h00);
        send(2'd1, 8'd10);
        tick();
        tick();
        check("abort_pre_jc", jc_q, 8'h03);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_jc", jc_q, 8'h03);
        check("abort_steps", steps_left, 8);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);

        // Reset in the middle of RUN 10
        send(2'd2, 8'h00);
        send(2'd1, 8'd10);
        repeat (4) tick();
        check("mid_jc", jc_q, 8'h0F);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", cmd_ready, 0);
        tick();
        check("mid_rst_jc", jc_q, 8'h00);
        check("mid_rst_steps", steps_left, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);
        tick();
        check("post_rst_nodone", done, 0);
        check("post_rst_jc", jc_q, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
